// File: rtl/d_branch_unit_pkg.sv
// d_branch_unit_pkg: branch op codes, counter states and saturating update shared by the branch unit
package d_branch_unit_pkg;
    localparam logic [2:0] CMP_none = 3'd0;
    localparam logic [2:0] CMP_beq  = 3'd1;
    localparam logic [2:0] CMP_bne  = 3'd2;
    localparam logic [2:0] CMP_blez = 3'd3;
    localparam logic [2:0] CMP_bgtz = 3'd4;
    localparam logic [2:0] CMP_bltz = 3'd5;
    localparam logic [2:0] CMP_bgez = 3'd6;
    localparam logic [2:0] CMP_rsv  = 3'd7;
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        return taken ? ((cnt == ST) ? ST : cnt + 2'd1) : ((cnt == SNT) ? SNT : cnt - 2'd1);
    endfunction
endpackage

// File: rtl/d_branch_unit_bht_counter_table.sv
// bht_counter_table: 2^IDX_W two-bit saturating counters, async read, sync update and reset
module bht_counter_table
    import d_branch_unit_pkg::*;
#(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    logic [1:0] cnt [2**IDX_W];
    assign rd_cnt = cnt[rd_idx];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**IDX_W; i++) cnt[i] <= CNT_INIT;
        end else if (wr_en) begin
            cnt[wr_idx] <= sat_next(cnt[wr_idx], wr_taken);
        end
    end
endmodule

// File: rtl/d_branch_unit.sv
// d_branch_unit: D-stage branch resolver with a 2-bit counter predictor table and branch statistics
module d_branch_unit
    import d_branch_unit_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = WNT,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       F_PC,
    output logic              F_pred_taken,
    input  logic [DATA_W-1:0] MF_Rs_D,
    input  logic [DATA_W-1:0] MF_Rt_D,
    input  logic [2:0]        D_BranchOp,
    input  logic [31:0]       D_PC,
    input  logic              D_pred_taken,
    input  logic              D_stall,
    output logic              BranchSignal,
    output logic              D_mispredict,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);
    logic       eq, neg, zero, valid, upd;
    logic [1:0] f_cnt;
    assign eq    = MF_Rs_D == MF_Rt_D;
    assign neg   = MF_Rs_D[DATA_W-1];
    assign zero  = MF_Rs_D == '0;
    assign valid = (D_BranchOp != CMP_none) && (D_BranchOp != CMP_rsv);
    assign upd   = valid && !D_stall;
    always_comb begin
        BranchSignal = (D_BranchOp == CMP_beq)  ? eq :
                       (D_BranchOp == CMP_bne)  ? !eq :
                       (D_BranchOp == CMP_blez) ? (neg || zero) :
                       (D_BranchOp == CMP_bgtz) ? !(neg || zero) :
                       (D_BranchOp == CMP_bltz) ? neg :
                       (D_BranchOp == CMP_bgez) ? !neg : 1'b0;
        D_mispredict = valid && (BranchSignal != D_pred_taken);
    end
    assign F_pred_taken = f_cnt[1];
    bht_counter_table #(.IDX_W(IDX_W), .CNT_INIT(CNT_INIT)) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (F_PC[IDX_W+1:2]),
        .rd_cnt   (f_cnt),
        .wr_en    (upd),
        .wr_idx   (D_PC[IDX_W+1:2]),
        .wr_taken (BranchSignal)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (upd) begin
            branch_cnt     <= branch_cnt + STAT_W'(1);
            mispredict_cnt <= mispredict_cnt + STAT_W'(D_mispredict);
        end
    end
endmodule

// File: tb/tb_d_branch_unit.sv
// tb_d_branch_unit: directed checks of branch resolution, prediction training, stall, bypass, aliasing and wrap
module tb_d_branch_unit;
    logic        clk = 0;
    logic        reset;
    logic [31:0] F_PC, MF_Rs_D, MF_Rt_D, D_PC;
    logic [2:0]  D_BranchOp;
    logic        D_pred_taken, D_stall;
    logic        F_pred_taken, BranchSignal, D_mispredict;
    logic [31:0] branch_cnt, mispredict_cnt;
    logic        s_pred, s_bs, s_mp;
    logic [3:0]  s_bcnt, s_mcnt;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    d_branch_unit dut (
        .clk(clk), .reset(reset), .F_PC(F_PC), .F_pred_taken(F_pred_taken),
        .MF_Rs_D(MF_Rs_D), .MF_Rt_D(MF_Rt_D), .D_BranchOp(D_BranchOp), .D_PC(D_PC),
        .D_pred_taken(D_pred_taken), .D_stall(D_stall), .BranchSignal(BranchSignal),
        .D_mispredict(D_mispredict), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    d_branch_unit #(.STAT_W(4)) dut_small (
        .clk(clk), .reset(reset), .F_PC(F_PC), .F_pred_taken(s_pred),
        .MF_Rs_D(MF_Rs_D), .MF_Rt_D(MF_Rt_D), .D_BranchOp(D_BranchOp), .D_PC(D_PC),
        .D_pred_taken(D_pred_taken), .D_stall(D_stall), .BranchSignal(s_bs),
        .D_mispredict(s_mp), .branch_cnt(s_bcnt), .mispredict_cnt(s_mcnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; F_PC = 32'h3000; MF_Rs_D = 0; MF_Rt_D = 0; D_BranchOp = 0;
        D_PC = 0; D_pred_taken = 0; D_stall = 0;
        step(); step();
        reset = 0; #1;
        total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_3000 got=%0b exp=0", F_pred_taken); end
        F_PC = 32'h3100; #1;
        total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_3100 got=%0b exp=0", F_pred_taken); end
        total++; if (branch_cnt !== 32'd0) begin bad++; $display("FAIL reset_branch_cnt got=%0d exp=0", branch_cnt); end
        total++; if (mispredict_cnt !== 32'd0) begin bad++; $display("FAIL reset_mispredict_cnt got=%0d exp=0", mispredict_cnt); end
    endtask

    task automatic test_beq_train();
        F_PC = 32'h3000; D_PC = 32'h3000; D_BranchOp = 3'd1; MF_Rs_D = 5; MF_Rt_D = 5; D_pred_taken = 0; #1;
        total++; if (BranchSignal !== 1'b1) begin bad++; $display("FAIL beq_taken got=%0b exp=1", BranchSignal); end
        total++; if (D_mispredict !== 1'b1) begin bad++; $display("FAIL beq_mispredict got=%0b exp=1", D_mispredict); end
        total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL beq_pred_before got=%0b exp=0", F_pred_taken); end
        step();
        total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL beq_pred_after1 got=%0b exp=1", F_pred_taken); end
        D_pred_taken = 1; #1;
        total++; if (D_mispredict !== 1'b0) begin bad++; $display("FAIL beq_no_mispredict got=%0b exp=0", D_mispredict); end
        step(); step();
        D_BranchOp = 0; #1;
        total++; if (branch_cnt !== 32'd3) begin bad++; $display("FAIL beq_branch_cnt got=%0d exp=3", branch_cnt); end
        total++; if (mispredict_cnt !== 32'd1) begin bad++; $display("FAIL beq_mispredict_cnt got=%0d exp=1", mispredict_cnt); end
        F_PC = 32'h3100; #1;
        total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL alias_pred_3100 got=%0b exp=1", F_pred_taken); end
        F_PC = 32'h3004; #1;
        total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL neighbour_pred_3004 got=%0b exp=0", F_pred_taken); end
    endtask

    task automatic test_signed();
        logic [2:0]  ops [10] = '{3'd5, 3'd3, 3'd4, 3'd6, 3'd3, 3'd6, 3'd4, 3'd5, 3'd7, 3'd0};
        logic [31:0] rs  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0};
        logic        exp [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        D_stall = 1; MF_Rt_D = 0; D_pred_taken = 1;
        for (int i = 0; i < 10; i++) begin
            D_BranchOp = ops[i]; MF_Rs_D = rs[i]; #1;
            total++; if (BranchSignal !== exp[i]) begin bad++; $display("FAIL signed_op%0d_rs%h got=%0b exp=%0b", ops[i], rs[i], BranchSignal, exp[i]); end
            total++; if (D_mispredict !== (ops[i] inside {3'd0, 3'd7} ? 1'b0 : !exp[i])) begin bad++; $display("FAIL signed_mp_op%0d got=%0b", ops[i], D_mispredict); end
        end
        D_BranchOp = 0; D_stall = 0;
    endtask

    task automatic test_stall();
        D_stall = 1; D_BranchOp = 3'd2; MF_Rs_D = 1; MF_Rt_D = 2; D_PC = 32'h3004; F_PC = 32'h3004; D_pred_taken = 0; #1;
        total++; if (BranchSignal !== 1'b1) begin bad++; $display("FAIL stall_bne got=%0b exp=1", BranchSignal); end
        step();
        total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL stall_pred got=%0b exp=0", F_pred_taken); end
        total++; if (branch_cnt !== 32'd3) begin bad++; $display("FAIL stall_branch_cnt got=%0d exp=3", branch_cnt); end
        total++; if (mispredict_cnt !== 32'd1) begin bad++; $display("FAIL stall_mispredict_cnt got=%0d exp=1", mispredict_cnt); end
        D_stall = 0; D_BranchOp = 0;
    endtask

    task automatic test_back_to_back();
        D_BranchOp = 3'd1; MF_Rs_D = 9; MF_Rt_D = 9; D_PC = 32'h3004; F_PC = 32'h3004; D_pred_taken = 0;
        step();
        D_BranchOp = 3'd2; MF_Rs_D = 7; MF_Rt_D = 7; D_pred_taken = 1; #1;
        total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL bypass_pred_same got=%0b exp=1", F_pred_taken); end
        total++; if (D_mispredict !== 1'b1) begin bad++; $display("FAIL bypass_mispredict got=%0b exp=1", D_mispredict); end
        step();
        D_BranchOp = 0; #1;
        total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL bypass_pred_next got=%0b exp=0", F_pred_taken); end
        total++; if (branch_cnt !== 32'd5) begin bad++; $display("FAIL b2b_branch_cnt got=%0d exp=5", branch_cnt); end
        total++; if (mispredict_cnt !== 32'd3) begin bad++; $display("FAIL b2b_mispredict_cnt got=%0d exp=3", mispredict_cnt); end
    endtask

    task automatic test_wrap();
        D_BranchOp = 3'd1; MF_Rs_D = 1; MF_Rt_D = 1; D_PC = 32'h3008; D_pred_taken = 1;
        for (int i = 0; i < 11; i++) step();
        D_BranchOp = 0; #1;
        total++; if (s_bcnt !== 4'd0) begin bad++; $display("FAIL wrap_small_branch_cnt got=%0d exp=0", s_bcnt); end
        total++; if (branch_cnt !== 32'd16) begin bad++; $display("FAIL wrap_branch_cnt got=%0d exp=16", branch_cnt); end
        total++; if (mispredict_cnt !== 32'd3) begin bad++; $display("FAIL wrap_mispredict_cnt got=%0d exp=3", mispredict_cnt); end
    endtask

    task automatic test_reset_dominant();
        D_BranchOp = 3'd1; MF_Rs_D = 4; MF_Rt_D = 4; D_PC = 32'h3008; F_PC = 32'h3008; D_pred_taken = 0; reset = 1;
        step();
        reset = 0; D_BranchOp = 0; #1;
        total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL rstdom_pred_3008 got=%0b exp=0", F_pred_taken); end
        F_PC = 32'h3000; #1;
        total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL rstdom_pred_3000 got=%0b exp=0", F_pred_taken); end
        total++; if (branch_cnt !== 32'd0) begin bad++; $display("FAIL rstdom_branch_cnt got=%0d exp=0", branch_cnt); end
        total++; if (mispredict_cnt !== 32'd0) begin bad++; $display("FAIL rstdom_mispredict_cnt got=%0d exp=0", mispredict_cnt); end
        D_BranchOp = 3'd1; D_PC = 32'h3000;
        step();
        D_BranchOp = 0; #1;
        total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL rstdom_retrain got=%0b exp=1", F_pred_taken); end
    endtask

    initial begin
        test_reset();
        test_beq_train();
        test_signed();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_reset_dominant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
